vending_machine_param: RTL and testbench
========================================

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 4: number of item slots, 2..16.
REQ-002 SHALL have parameter CREDIT_W, default 4: width of credit, change and refund values.
REQ-003 SHALL have parameter PRICES, default {6,5,4,3}: packed NUM_ITEMS*CREDIT_W vector, item i at bits [i*CREDIT_W +: CREDIT_W].
- Each price SHALL be 1..2^CREDIT_W-1; a simulation-time check SHALL flag a violation.
REQ-004 SHALL have parameter STOCK_W, default 3: width of each per-item stock counter.
REQ-005 SHALL have parameter STOCK_INIT, default 7: reset value of every stock counter.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 16: inactivity limit in WAIT_COIN.
REQ-007 Port clk, input, 1: single clock; all state updates on posedge.
REQ-008 Port rst, input, 1: reset, synchronous and active-low.
REQ-009 Port sel, input, NUM_ITEMS: item select; only an exactly one-hot value is valid.
REQ-010 Port c1 / c2, input, 1 each: coin of value 1 / 2, one pulse per coin.
REQ-011 Port cnl, input, 1: cancel request.
REQ-012 Port restock_valid, input, 1, with restock_id, input, clog2(NUM_ITEMS): add one unit to item restock_id.
REQ-013 Port pdt, output, 1: item released; pulse.
REQ-014 Port pdt_id, output, clog2(NUM_ITEMS): index of the released item.
REQ-015 Port cng, output, CREDIT_W: change amount, valid with pdt.
REQ-016 Port rtn, output, CREDIT_W: refunded credit; nonzero for one cycle.
REQ-017 Port sold_out, output, NUM_ITEMS: bit i high while stock[i]==0.
REQ-018 Port err, output, 1: pulse when a sold-out item is selected.
REQ-019 Port coin_rej, output, 1: pulse when a coin is rejected.
REQ-020 Port timeout, output, 1: pulse when a refund is caused by timeout.

Function
REQ-021 FSM states SHALL be IDLE, WAIT_COIN, VEND and REFUND.
- pdt, rtn, cng, err, coin_rej and timeout SHALL all be registered.
- Each is asserted during the single cycle following the edge that causes it, and is zero otherwise.
REQ-022 IDLE: on a one-hot sel with stock nonzero, the FSM SHALL latch the index, clear credit and go to WAIT_COIN.
- If that stock is zero: err=1 and the FSM stays in IDLE.
- A non-one-hot sel, coins and cnl SHALL be ignored.
REQ-023 Coins SHALL be accepted only in WAIT_COIN.
- Added value: c1=1, c2=2, c1&c2 in the same cycle=3.
- credit_next = credit + value.
REQ-024 If credit_next exceeds 2^CREDIT_W-1, the coin SHALL be rejected: coin_rej=1, credit unchanged.
REQ-025 If credit_next >= price, then at the same edge the FSM SHALL:
- go to VEND;
- set pdt=1, pdt_id=index, cng=credit_next-price;
- decrement stock[index].
- Latency is one edge from the completing coin.
REQ-026 cnl, or any nonzero sel, in WAIT_COIN SHALL cause a transition to REFUND with rtn = credit_next, so a coin arriving in the same cycle is refunded.
- Cancel SHALL have priority over vend in the same cycle.
REQ-027 VEND and REFUND SHALL return to IDLE after exactly one cycle, with credit cleared; inputs in these states are ignored.
REQ-028 restock_valid SHALL increment stock[restock_id] in any state, saturating at 2^STOCK_W-1.
- A restock_id >= NUM_ITEMS SHALL be ignored.
- A restock and a vend of the same item in one cycle SHALL leave the stock count unchanged.
REQ-029 sold_out SHALL be combinational from the stock registers.

Reset
REQ-030 When rst=0 at a posedge, the block SHALL reset to:
- state=IDLE, credit=0;
- pdt=0, pdt_id=0, cng=0, rtn=0, err=0, coin_rej=0, timeout=0;
- all stock counters = STOCK_INIT;
- timeout counter = 0.
REQ-031 A reset in any state, including mid-transaction, SHALL discard credit without issuing rtn.

Configuration
REQ-032 Macro VM_TIMEOUT_EN defined:
- In WAIT_COIN, a counter SHALL clear on each accepted coin and increment on each cycle without one.
- On reaching TIMEOUT_CYC, the FSM SHALL go to REFUND with rtn=credit and timeout=1.
REQ-033 Macro VM_TIMEOUT_EN undefined:
- No counter SHALL be built, WAIT_COIN waits indefinitely, and timeout is tied to 0.

Verification
REQ-034 rst=0 for 2 cycles -> all outputs 0, sold_out=0000, stock all 7.
REQ-035 sel=0001, c2, c2 -> after the 2nd coin pdt=1 for one cycle, pdt_id=0, cng=1, stock[0]=6.
REQ-036 sel=0010, c1, then cnl together with c2 -> rtn=3 for one cycle, pdt never asserted.
REQ-037 sel=0100, c1&c2 in one cycle, then c2 -> pdt=1, pdt_id=2, cng=0.
REQ-038 7 vends of item 3 -> sold_out=1000; sel=1000 -> err=1 and FSM stays IDLE; restock_id=3 -> sold_out=0000.
REQ-039 With VM_TIMEOUT_EN: sel=0001, c1, then 16 idle cycles -> rtn=1, timeout=1, FSM returns to IDLE.

Source files
------------

// File: rtl/vending_machine_param.sv
// Parameterised vending machine: item select, coin credit, change, refund and per-item stock.
// Define VM_TIMEOUT_EN to build the WAIT_COIN inactivity timeout; otherwise timeout is tied low.
module vending_machine_param #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int STOCK_W = 3,
  parameter int STOCK_INIT = 7,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ITEMS-1:0]         sel,
  input  logic                         c1,
  input  logic                         c2,
  input  logic                         cnl,
  input  logic                         restock_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_id,
  output logic                         pdt,
  output logic [$clog2(NUM_ITEMS)-1:0] pdt_id,
  output logic [CREDIT_W-1:0]          cng,
  output logic [CREDIT_W-1:0]          rtn,
  output logic [NUM_ITEMS-1:0]         sold_out,
  output logic                         err,
  output logic                         coin_rej,
  output logic                         timeout
);
  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_COIN = 2'd1, VEND = 2'd2, REFUND = 2'd3} state_t;

  state_t               state_r, state_nxt_s;
  logic [CREDIT_W-1:0]  credit_r, credit_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic [STOCK_W-1:0]   stock_r [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] inc_s, dec_s;
  logic                 sel_onehot_s, stock_ok_s, in_wait_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [CREDIT_W:0]    coin_sum_s;
  logic [CREDIT_W-1:0]  credit_eff_s, price_s;
  logic                 coin_any_s, coin_ovf_s, coin_acc_s;
  logic                 cancel_s, vend_s, tmo_fire_s;
  logic                 pdt_nxt_s, err_nxt_s, coin_rej_nxt_s, timeout_nxt_s;
  logic [IDX_W-1:0]     pdt_id_nxt_s;
  logic [CREDIT_W-1:0]  cng_nxt_s, rtn_nxt_s;

  function automatic logic is_onehot(input logic [NUM_ITEMS-1:0] v);
    return (v != {NUM_ITEMS{1'b0}}) && ((v & (v - NUM_ITEMS'(1))) == {NUM_ITEMS{1'b0}});
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_ITEMS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign sel_onehot_s = is_onehot(sel);
  assign sel_idx_s    = onehot_idx(sel);
  assign stock_ok_s   = (stock_r[sel_idx_s] != {STOCK_W{1'b0}});
  assign in_wait_s    = (state_r == WAIT_COIN);
  assign price_s      = PRICES[int'(idx_r)*CREDIT_W +: CREDIT_W];

  // A carry out of the credit width means the coin would overflow and is rejected.
  assign coin_sum_s   = {1'b0, credit_r} + {{(CREDIT_W-1){1'b0}}, c2, c1};
  assign coin_any_s   = c1 | c2;
  assign coin_ovf_s   = coin_sum_s[CREDIT_W];
  assign coin_acc_s   = coin_any_s & ~coin_ovf_s;
  assign credit_eff_s = coin_ovf_s ? credit_r : coin_sum_s[CREDIT_W-1:0];
  assign cancel_s     = in_wait_s & (cnl | (sel != {NUM_ITEMS{1'b0}}));
  assign vend_s       = in_wait_s & ~cancel_s & coin_acc_s & (credit_eff_s >= price_s);

`ifdef VM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  assign tmo_fire_s = in_wait_s & ~cancel_s & ~vend_s & ~coin_acc_s &
                      (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

  // Inactivity counter: runs only in WAIT_COIN, cleared by every accepted coin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (!in_wait_s || coin_acc_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end
`else
  assign tmo_fire_s = 1'b0;
`endif

  // State, credit and selected-item registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      credit_r <= {CREDIT_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      credit_r <= credit_nxt_s;
      idx_r    <= idx_nxt_s;
    end
  end

  // Next-state logic; cancel outranks vend, vend outranks timeout.
  always_comb begin
    state_nxt_s  = state_r;
    credit_nxt_s = credit_r;
    idx_nxt_s    = idx_r;
    case (state_r)
      IDLE: begin
        if (sel_onehot_s && stock_ok_s) begin
          state_nxt_s  = WAIT_COIN;
          idx_nxt_s    = sel_idx_s;
          credit_nxt_s = {CREDIT_W{1'b0}};
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      WAIT_COIN: begin
        if (cancel_s || tmo_fire_s) begin
          state_nxt_s  = REFUND;
          credit_nxt_s = {CREDIT_W{1'b0}};
        end else if (vend_s) begin
          state_nxt_s  = VEND;
          credit_nxt_s = {CREDIT_W{1'b0}};
        end else begin
          credit_nxt_s = credit_eff_s;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        credit_nxt_s = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // Next values of the pulsed outputs.
  always_comb begin
    pdt_nxt_s      = 1'b0;
    pdt_id_nxt_s   = {IDX_W{1'b0}};
    cng_nxt_s      = {CREDIT_W{1'b0}};
    rtn_nxt_s      = {CREDIT_W{1'b0}};
    err_nxt_s      = 1'b0;
    coin_rej_nxt_s = 1'b0;
    timeout_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_onehot_s && !stock_ok_s) err_nxt_s = 1'b1;
        else err_nxt_s = 1'b0;
      end
      WAIT_COIN: begin
        coin_rej_nxt_s = coin_any_s & coin_ovf_s;
        if (cancel_s) begin
          rtn_nxt_s     = credit_eff_s;
        end else if (vend_s) begin
          pdt_nxt_s     = 1'b1;
          pdt_id_nxt_s  = idx_r;
          cng_nxt_s     = credit_eff_s - price_s;
        end else if (tmo_fire_s) begin
          rtn_nxt_s     = credit_r;
          timeout_nxt_s = 1'b1;
        end else begin
          rtn_nxt_s     = {CREDIT_W{1'b0}};
        end
      end
      default: begin
        pdt_nxt_s      = 1'b0;
      end
    endcase
  end

  // Output registers; reset drops any pending credit without a refund.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pdt      <= 1'b0;
      pdt_id   <= {IDX_W{1'b0}};
      cng      <= {CREDIT_W{1'b0}};
      rtn      <= {CREDIT_W{1'b0}};
      err      <= 1'b0;
      coin_rej <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      pdt      <= pdt_nxt_s;
      pdt_id   <= pdt_id_nxt_s;
      cng      <= cng_nxt_s;
      rtn      <= rtn_nxt_s;
      err      <= err_nxt_s;
      coin_rej <= coin_rej_nxt_s;
      timeout  <= timeout_nxt_s;
    end
  end

  // Per-item restock and vend strobes.
  always_comb begin
    inc_s = {NUM_ITEMS{1'b0}};
    dec_s = {NUM_ITEMS{1'b0}};
    for (int i = 0; i < NUM_ITEMS; i++) begin
      inc_s[i] = restock_valid && (restock_id == IDX_W'(i));
      dec_s[i] = vend_s && (idx_r == IDX_W'(i));
    end
  end

  // Stock counters: saturating restock; restock plus vend of one item cancels out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (!rst) begin
        stock_r[i] <= STOCK_W'(STOCK_INIT);
      end else if (inc_s[i] && !dec_s[i] && (stock_r[i] != STOCK_MAX)) begin
        stock_r[i] <= stock_r[i] + STOCK_W'(1);
      end else if (dec_s[i] && !inc_s[i]) begin
        stock_r[i] <= stock_r[i] - STOCK_W'(1);
      end else begin
        stock_r[i] <= stock_r[i];
      end
    end
  end

  // Sold-out flags follow the stock registers directly.
  always_comb begin
    sold_out = {NUM_ITEMS{1'b0}};
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out[i] = (stock_r[i] == {STOCK_W{1'b0}});
    end
  end

  vending_machine_param_chk #(
    .NUM_ITEMS  (NUM_ITEMS),
    .CREDIT_W   (CREDIT_W),
    .PRICES     (PRICES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_chk (
    .clk(clk)
  );
endmodule

// Parameter sanity checks: every price must be nonzero, timeout at least one cycle.
module vending_machine_param_chk #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int TIMEOUT_CYC = 16
) (
  input logic clk
);
  function automatic logic prices_ok();
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (PRICES[i*CREDIT_W +: CREDIT_W] == {CREDIT_W{1'b0}}) ok = 1'b0;
    end
    return ok;
  endfunction

  // Flag an illegal configuration on every clock.
  always @(posedge clk) begin
    assert (prices_ok() && (TIMEOUT_CYC >= 1))
      else $error("vending_machine_param: a price is zero or TIMEOUT_CYC < 1");
  end
endmodule

// File: tb/tb_vending_machine_param.sv
// Randomised scoreboard bench for vending_machine_param against a transaction-level model.
module tb_vending_machine_param;
  localparam int N = 4, CW = 4, IW = 2, SMAX = 7, CMAX = 15, TMO = 16;

  logic clk = 1'b0, rst;
  logic [N-1:0] sel, sold_out;
  logic c1, c2, cnl, restock_valid, pdt, err, coin_rej, timeout;
  logic [IW-1:0] restock_id, pdt_id;
  logic [CW-1:0] cng, rtn;

  always #5 clk = ~clk;

  vending_machine_param dut (
    .clk(clk), .rst(rst), .sel(sel), .c1(c1), .c2(c2), .cnl(cnl),
    .restock_valid(restock_valid), .restock_id(restock_id),
    .pdt(pdt), .pdt_id(pdt_id), .cng(cng), .rtn(rtn), .sold_out(sold_out),
    .err(err), .coin_rej(coin_rej), .timeout(timeout)
  );

  typedef struct {
    int cyc; logic pdt; logic [IW-1:0] id; logic [CW-1:0] cng; logic [CW-1:0] rtn;
    logic err; logic rej; logic tmo;
  } ev_t;

  ev_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 1'b0;
  int price[N] = '{3, 4, 5, 6};
  int stock[N];
  bit paying, settling;
  int item, credit, tmo;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) stock[i] = SMAX;
    paying = 0; settling = 0; credit = 0; tmo = 0; item = 0;
  endfunction

  // One clock of the customer-level rules; pushes the visible response, if any.
  task automatic model_step(input logic [N-1:0] s, input logic a1, input logic a2,
                            input logic cn, input logic rv, input logic [IW-1:0] rid);
    ev_t e;
    int val, nxt, k;
    bit rej;
    e.cyc = cyc + 1; e.pdt = 0; e.id = '0; e.cng = '0; e.rtn = '0;
    e.err = 0; e.rej = 0; e.tmo = 0;
    if (settling) begin
      settling = 0;
    end else if (!paying) begin
      if ($countones(s) == 1) begin
        k = 0;
        for (int i = 0; i < N; i++) if (s[i]) k = i;
        if (stock[k] > 0) begin
          paying = 1; item = k; credit = 0; tmo = 0;
        end else e.err = 1;
      end
    end else begin
      val = int'(a1) + 2 * int'(a2);
      nxt = credit + val;
      rej = (nxt > CMAX);
      if (rej) nxt = credit;
      e.rej = rej;
      if (cn || s != '0) begin
        e.rtn = CW'(nxt); paying = 0; settling = 1;
      end else if (nxt >= price[item]) begin
        e.pdt = 1; e.id = IW'(item); e.cng = CW'(nxt - price[item]);
        stock[item] = stock[item] - 1; paying = 0; settling = 1;
      end else begin
        credit = nxt;
`ifdef VM_TIMEOUT_EN
        if (val != 0 && !rej) tmo = 0;
        else begin
          tmo = tmo + 1;
          if (tmo == TMO) begin
            e.rtn = CW'(credit); e.tmo = 1; paying = 0; settling = 1;
          end
        end
`endif
      end
    end
    if (rv && int'(rid) < N) stock[rid] = (stock[rid] + 1 > SMAX) ? SMAX : stock[rid] + 1;
    if (e.pdt || e.err || e.rej || e.tmo || e.rtn != '0) sb.push_back(e);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (after checking sold_out against the model).
  task automatic step(input logic [N-1:0] s, input logic a1, input logic a2,
                      input logic cn, input logic rv, input logic [IW-1:0] rid);
    logic [N-1:0] exp_so;
    for (int i = 0; i < N; i++) exp_so[i] = (stock[i] == 0);
    check_eq("sold_out", 32'(sold_out), 32'(exp_so));
    sel = s; c1 = a1; c2 = a2; cnl = cn; restock_valid = rv; restock_id = rid;
    model_step(s, a1, a2, cn, rv, rid);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0; sel = '0; c1 = 0; c2 = 0; cnl = 0; restock_valid = 0; restock_id = '0;
    @(posedge clk); #1;
    sb.delete();
    @(posedge clk); #1;
    model_reset();
    check_eq("reset_outputs", 32'({pdt, pdt_id, cng, rtn, err, coin_rej, timeout}), 32'd0);
    check_eq("reset_sold_out", 32'(sold_out), 32'd0);
    rst = 1'b1;
  endtask

  // Scoreboard monitor: every DUT response must match the queued expectation for that cycle.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_event: nothing seen, expected pdt=%0b id=%0d cng=%0d rtn=%0d err=%0b rej=%0b tmo=%0b at cycle %0d",
                 sb[0].pdt, sb[0].id, sb[0].cng, sb[0].rtn, sb[0].err, sb[0].rej, sb[0].tmo, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (pdt || err || coin_rej || timeout || rtn != '0 || cng != '0) begin
        checks++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_event cycle %0d: got pdt=%0b id=%0d cng=%0d rtn=%0d err=%0b rej=%0b tmo=%0b, expected none",
                   cyc, pdt, pdt_id, cng, rtn, err, coin_rej, timeout);
        end else begin
          e = sb.pop_front();
          if ({pdt, (pdt ? pdt_id : e.id), cng, rtn, err, coin_rej, timeout} !==
              {e.pdt, e.id, e.cng, e.rtn, e.err, e.rej, e.tmo}) begin
            errors++;
            $display("FAIL event cycle %0d: got pdt=%0b id=%0d cng=%0d rtn=%0d err=%0b rej=%0b tmo=%0b, expected pdt=%0b id=%0d cng=%0d rtn=%0d err=%0b rej=%0b tmo=%0b",
                     cyc, pdt, pdt_id, cng, rtn, err, coin_rej, timeout,
                     e.pdt, e.id, e.cng, e.rtn, e.err, e.rej, e.tmo);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] s;
    int r;
    model_reset();
    do_reset();
    mon_en = 1'b1;

    // Item 0 with two 2-coins: change 1.
    step(4'b0001, 0, 0, 0, 0, '0); step('0, 0, 1, 0, 0, '0); step('0, 0, 1, 0, 0, '0); idle(2);
    // Item 1: 1-coin then cancel together with a 2-coin refunds 3.
    step(4'b0010, 0, 0, 0, 0, '0); step('0, 1, 0, 0, 0, '0); step('0, 0, 1, 1, 0, '0); idle(2);
    // Item 2: double coin then a 2-coin, exact price.
    step(4'b0100, 0, 0, 0, 0, '0); step('0, 1, 1, 0, 0, '0); step('0, 0, 1, 0, 0, '0); idle(2);
    // Reset mid-transaction discards credit silently.
    step(4'b0001, 0, 0, 0, 0, '0); step('0, 0, 1, 0, 0, '0);
    do_reset();
    // Empty item 3, hit the sold-out error, then restock it.
    for (int v = 0; v < 7; v++) begin
      step(4'b1000, 0, 0, 0, 0, '0);
      step('0, 0, 1, 0, 0, '0); step('0, 0, 1, 0, 0, '0); step('0, 0, 1, 0, 0, '0);
      idle(1);
    end
    idle(1);
    check_eq("sold_out_item3", 32'(sold_out), 32'b1000);
    step(4'b1000, 0, 0, 0, 0, '0);
    step('0, 0, 1, 0, 0, '0); step('0, 0, 1, 0, 0, '0); step('0, 0, 1, 0, 0, '0);
    step('0, 0, 0, 0, 1, 2'd3); idle(1);
    check_eq("sold_out_restocked", 32'(sold_out), 32'b0000);
`ifdef VM_TIMEOUT_EN
    step(4'b0001, 0, 0, 0, 0, '0); step('0, 1, 0, 0, 0, '0); idle(TMO + 2);
`endif

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) s = 4'b0001 << $urandom_range(0, N - 1);
      else if (r < 15) s = N'($urandom_range(0, 15));
      else s = '0;
      step(s, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 8), IW'($urandom_range(0, N - 1)));
      if (i % 1000 == 999) do_reset();
    end

    idle(5);
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
